// File: rtl/game_timer_pkg.sv
// game_timer_pkg: shared types, constants and BCD helper functions for the
// game countdown timer and the score block.
//   timer_state_t : countdown FSM states
//   bcd2_t        : two BCD digits, [1] = tens, [0] = units
//   MAX_BCD       : saturation value for two-digit BCD (99)
package game_timer_pkg;

    typedef enum logic [1:0] {RUNNING, FROZEN, EXPIRED} timer_state_t;

    typedef logic [1:0][3:0] bcd2_t;

    localparam bcd2_t MAX_BCD = 8'h99;

    // Non-decimal nibbles are treated as 9.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [7:0] bcd2_to_bin(input bcd2_t v);
        return 8'(v[1]) * 8'd10 + 8'(v[0]);
    endfunction

    // Caller guarantees b <= 99.
    function automatic bcd2_t bin_to_bcd2(input logic [7:0] b);
        return {4'(b / 8'd10), 4'(b % 8'd10)};
    endfunction

endpackage

// File: rtl/game_timer_bcd2_sat_addsub.sv
// bcd2_sat_addsub: combinational two-digit BCD "decrement then add" with
// saturation at 00 (decrement) and 99 (add).
//   value  : current BCD value
//   dec    : subtract one before the add (no-op at 00)
//   addend : BCD amount to add; digits above 9 are clamped to 9
//   result : min(max(value - dec, 0) + addend, 99) in BCD
//   zero   : result is 00
module bcd2_sat_addsub
    import game_timer_pkg::*;
(
    input  logic [1:0][3:0] value,
    input  logic            dec,
    input  logic [1:0][3:0] addend,
    output logic [1:0][3:0] result,
    output logic            zero
);

    logic [7:0] val_bin;
    logic [7:0] add_bin;
    logic [7:0] base_bin;
    logic [7:0] sum_bin;

    // Work in binary: both operands are at most 99, so the sum fits in 8 bits.
    always_comb begin
        val_bin  = bcd2_to_bin({clamp_digit(value[1]), clamp_digit(value[0])});
        add_bin  = bcd2_to_bin({clamp_digit(addend[1]), clamp_digit(addend[0])});
        base_bin = (dec && (val_bin != 8'd0)) ? (val_bin - 8'd1) : val_bin;
        sum_bin  = base_bin + add_bin;
        result   = (sum_bin > 8'd99) ? MAX_BCD : bin_to_bcd2(sum_bin);
        zero     = (result == '0);
    end

endmodule

// File: rtl/game_timer.sv
// game_timer: two-digit BCD countdown driven by startOfFrame, with bonus-time
// addition, sticky out-of-time flag, low-time warning and warning blink.
//   clk, resetN    : clock, synchronous active-low reset
//   startOfFrame   : one-clk pulse per video frame
//   player_active  : low freezes the countdown
//   add_time       : one-clk bonus request, amount on time_to_add (BCD)
//   time_digits    : current time, BCD [1]=tens [0]=units
//   out_of_time    : sticky expiry flag
//   low_time       : running with 0 < time < WARN_SECS
//   blink          : toggles every BLINK_FRAMES frames while low_time
module game_timer
    import game_timer_pkg::*;
#(
    parameter int unsigned FRAMES_PER_SEC = 30,
    parameter int unsigned INIT_TIME      = 99,
    parameter int unsigned WARN_SECS      = 10,
    parameter int unsigned BLINK_FRAMES   = 8
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            startOfFrame,
    input  logic            player_active,
    input  logic            add_time,
    input  logic [1:0][3:0] time_to_add,
    output logic [1:0][3:0] time_digits,
    output logic            out_of_time,
    output logic            low_time,
    output logic            blink
);

    localparam int unsigned DIV_W   = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(FRAMES_PER_SEC - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam bcd2_t INIT_BCD = {4'(INIT_TIME / 10), 4'(INIT_TIME % 10)};
    localparam timer_state_t INIT_STATE = (INIT_TIME == 0) ? EXPIRED : RUNNING;

    timer_state_t       state, state_next;
    logic [DIV_W-1:0]   div_cnt, div_next;
    logic [BLINK_W-1:0] blink_cnt, blink_cnt_next;
    bcd2_t              addend, sum, time_next;
    logic               sum_zero;
    logic               tick, add_en;
    logic               out_of_time_next, low_time_next, blink_next;
    logic [7:0]         time_next_bin;

    always_comb begin
        tick   = (state == RUNNING) && startOfFrame && (div_cnt == DIV_LAST);
        add_en = add_time && (state != EXPIRED);
        addend = add_en ? bcd2_t'(time_to_add) : '0;
    end

    bcd2_sat_addsub u_addsub (
        .value  (time_digits),
        .dec    (tick),
        .addend (addend),
        .result (sum),
        .zero   (sum_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state <= INIT_STATE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; expiry needs the tick to land on 00 with no bonus,
    // which sum_zero already captures because the bonus is folded into sum.
    always_comb begin
        state_next = state;
        case (state)
            RUNNING: begin
                if (tick && sum_zero) begin
                    state_next = EXPIRED;
                end else if (!player_active) begin
                    state_next = FROZEN;
                end
            end
            FROZEN: begin
                if (player_active) begin
                    state_next = RUNNING;
                end
            end
            EXPIRED: state_next = EXPIRED;
            default: state_next = RUNNING;
        endcase
    end

    // Output / datapath next values. Flags are derived from the next state
    // and next time so they line up with the registered time_digits.
    always_comb begin
        time_next = (tick || add_en) ? sum : time_digits;

        div_next = div_cnt;
        if ((state == RUNNING) && startOfFrame) begin
            div_next = tick ? '0 : div_cnt + DIV_W'(1);
        end

        time_next_bin    = bcd2_to_bin(time_next);
        out_of_time_next = (state_next == EXPIRED);
        low_time_next    = (state_next == RUNNING) && (time_next_bin != 8'd0)
                           && (32'(time_next_bin) < WARN_SECS);

        blink_cnt_next = blink_cnt;
        blink_next     = blink;
        if (!low_time_next) begin
            blink_cnt_next = '0;
            blink_next     = 1'b0;
        end else if (startOfFrame) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_next = '0;
                blink_next     = ~blink;
            end else begin
                blink_cnt_next = blink_cnt + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            div_cnt     <= '0;
            blink_cnt   <= '0;
            time_digits <= INIT_BCD;
            out_of_time <= (INIT_TIME == 0);
            low_time    <= 1'b0;
            blink       <= 1'b0;
        end else begin
            div_cnt     <= div_next;
            blink_cnt   <= blink_cnt_next;
            time_digits <= time_next;
            out_of_time <= out_of_time_next;
            low_time    <= low_time_next;
            blink       <= blink_next;
        end
    end

endmodule
